pll_lock_sequencer: RTL
=======================

// Module: pll_lock_sequencer
// PURPOSE
//  Sequences the ECP5 PLL wrapper (pll) after configuration. Drives its reset, waits for
//  LOCK, and qualifies lock stability before releasing the core reset. Detects lock loss,
//  re-locks with bounded retries, and counts relock events.
//  Runs on the board input clock (clki of the PLL), never on the PLL output.
// PARAMETERS
//  RST_CYCLES    16     cycles o_pll_rst is held high per PLL reset attempt (>=1)
//  LOCK_TIMEOUT  65536  cycles allowed in WAIT_LOCK before a retry (>=2)
//  STABLE_CYCLES 1024   consecutive synced-lock cycles required before RUN (>=1)
//  MAX_RETRIES   7      consecutive lock timeouts before entering FAIL (1..15)
// PORTS
//  i_clk         in   1  board reference clock
//  i_rst         in   1  synchronous, active-high reset
//  i_locked      in   1  PLL LOCK, asynchronous to i_clk
//  i_force       in   1  single-cycle request to re-run the full PLL reset sequence
//  o_pll_rst     out  1  to PLL RST, active high
//  o_sys_rst     out  1  core reset request, active high (consumer synchronises into clko)
//  o_ready       out  1  high only in RUN
//  o_fail        out  1  high only in FAIL
//  o_relock_cnt  out  8  lock-loss events seen in RUN, saturates at 255
//  o_state       out  3  current state encoding (debug)
// BEHAVIOUR
//  - Reset (i_rst=1): state=PLL_RST, counter=0, retries=0, o_relock_cnt=0, synchroniser=0,
//    o_pll_rst=1, o_sys_rst=1, o_ready=0, o_fail=0.
//  - i_locked passes a 2-flop synchroniser -> lock_s; 2-cycle latency to the FSM.
//  - States (o_state): PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
//  - One shared cycle counter; it clears on every state change.
//  - PLL_RST: o_pll_rst=1. Leaves to WAIT_LOCK when counter==RST_CYCLES-1,
//    so o_pll_rst is high for exactly RST_CYCLES cycles.
//  - WAIT_LOCK: on lock_s -> STABLE. On counter==LOCK_TIMEOUT-1 without lock, retries++:
//    if the new value == MAX_RETRIES -> FAIL, else -> PLL_RST.
//  - STABLE: lock_s low -> WAIT_LOCK (no retry increment).
//    counter==STABLE_CYCLES-1 with lock_s high -> RUN and retries cleared.
//  - RUN: o_sys_rst=0, o_ready=1. lock_s low -> PLL_RST and o_relock_cnt++ (saturating).
//  - FAIL: o_pll_rst=1, o_sys_rst=1, o_fail=1. Sticky; exits only via i_force or i_rst.
//  - i_force in any state except PLL_RST -> PLL_RST with retries cleared.
//    i_force in PLL_RST is ignored; the counter is not restarted.
//  - Simultaneous events:
//    - RUN with lock loss and i_force: go to PLL_RST and still count the relock.
//    - WAIT_LOCK with timeout and lock_s: lock wins, go to STABLE.
//    - i_force at FAIL entry: FAIL is skipped, go to PLL_RST.
//  - All outputs are registered and align with the state register. o_sys_rst rises the cycle
//    after lock loss is seen and is high in every state except RUN.
//  - o_pll_rst=1 in PLL_RST and FAIL only.
//  - i_rst mid-operation aborts any state at once and restores the reset values above.
// STRUCTURE
//  - Shared package/header pll_seq_pkg: state encodings, state width (3),
//    relock counter width (8), and a counter-width function $clog2(max(RST_CYCLES,
//    LOCK_TIMEOUT, STABLE_CYCLES)).
//  - Sub-module pll_lock_sync: parameterised N-flop synchroniser (N=2), reset to 0.
//  - FSM, counter and outputs live in the top module.
// TESTING  (RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=3)
//  - Clean boot: release i_rst; raise i_locked at cycle 10 and hold it.
//    -> o_pll_rst high for cycles 0-3; o_ready=1 and o_sys_rst=0 at cycle 10+2+8(+-1).
//  - Lock glitch: in STABLE, drop i_locked for 1 cycle.
//    -> back to WAIT_LOCK, stability counter restarts, RUN entered 8 cycles after lock returns.
//  - Lock loss in RUN: drop i_locked.
//    -> o_sys_rst=1 within 3 cycles, o_pll_rst pulses for 4 cycles, o_relock_cnt=1.
//    Repeat 300 times -> o_relock_cnt stays 255.
//  - Never lock. -> three PLL_RST/WAIT_LOCK rounds of 4+32 cycles, then o_fail=1 and
//    o_pll_rst=1 held. Pulse i_force -> PLL_RST with retries=0, and the bench then boots.
//  - i_force in RUN together with lock loss. -> PLL_RST, o_relock_cnt increments.
//    i_force in PLL_RST -> no change to the 4-cycle reset width.
//  - Assert i_rst for 1 cycle while in STABLE. -> every output returns to its reset value
//    the next cycle, and o_relock_cnt=0.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock sequencer: state encodings, field widths
// and the sizing rule for the shared cycle counter.
package pll_seq_pkg;

    localparam int STATE_W     = 3;
    localparam int RELOCK_W    = 8;
    localparam int RETRY_W     = 4;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_e;

    // Wide enough to reach the largest terminal count; never narrower than one bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// N-flop synchroniser used to bring the asynchronous PLL LOCK into the
// reference-clock domain; all stages clear to zero on reset.
module pll_lock_sync #(
    parameter int N = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [N-1:0] stages;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stages <= '0;
        end else begin
            stages <= {stages[N-2:0], i_d};
        end
    end

    assign o_q = stages[N-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Drives the PLL reset, qualifies a stable LOCK before releasing the core reset,
// re-locks after lock loss with bounded retries and counts relock events.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 7
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_locked,
    input  logic                i_force,
    output logic                o_pll_rst,
    output logic                o_sys_rst,
    output logic                o_ready,
    output logic                o_fail,
    output logic [RELOCK_W-1:0] o_relock_cnt,
    output logic [STATE_W-1:0]  o_state
);

    localparam int CW = cnt_width(int'(RST_CYCLES), int'(LOCK_TIMEOUT), int'(STABLE_CYCLES));

    localparam logic [CW-1:0]      RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0]      TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0]      STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

    state_e                state, state_nx;
    logic [CW-1:0]         cnt;
    logic [RETRY_W-1:0]    retries, retries_nx, retries_inc;
    logic [RELOCK_W-1:0]   relock, relock_nx;
    logic                  lock_s;

    pll_lock_sync #(.N(SYNC_STAGES)) u_lock_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_locked),
        .o_q   (lock_s)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_nx    = state;
        retries_nx  = retries;
        relock_nx   = relock;
        retries_inc = retries + 1'b1;

        case (state)
            ST_PLL_RST: begin
                if (cnt == RST_LAST) state_nx = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // A lock arriving on the timeout cycle takes priority over the retry.
                if (lock_s) begin
                    state_nx = ST_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    retries_nx = retries_inc;
                    state_nx   = (retries_inc == RETRY_LIMIT) ? ST_FAIL : ST_PLL_RST;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_nx = ST_WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    state_nx   = ST_RUN;
                    retries_nx = '0;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_nx = ST_PLL_RST;
                    if (relock != '1) relock_nx = relock + 1'b1;
                end
            end
            ST_FAIL: begin
                state_nx = ST_FAIL;
            end
            default: begin
                state_nx = ST_PLL_RST;
            end
        endcase

        // A force overrides every other transition, including FAIL entry; the
        // relock count update above is kept.
        if (i_force && state != ST_PLL_RST) begin
            state_nx   = ST_PLL_RST;
            retries_nx = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (i_rst) begin
            state     <= ST_PLL_RST;
            cnt       <= '0;
            retries   <= '0;
            relock    <= '0;
            o_pll_rst <= 1'b1;
            o_sys_rst <= 1'b1;
            o_ready   <= 1'b0;
            o_fail    <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= (state_nx != state) ? '0 : cnt + 1'b1;
            retries   <= retries_nx;
            relock    <= relock_nx;
            // Outputs are decoded from the next state so they line up with the state register.
            o_pll_rst <= (state_nx == ST_PLL_RST) || (state_nx == ST_FAIL);
            o_sys_rst <= (state_nx != ST_RUN);
            o_ready   <= (state_nx == ST_RUN);
            o_fail    <= (state_nx == ST_FAIL);
        end
    end

    assign o_relock_cnt = relock;
    assign o_state      = state;

endmodule
